// File: rtl/uart_regfile_master.sv
// uart_regfile_master: host-side initiator that sends regfile UART packets, fetches read replies and reports status
module uart_regfile_master #(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_W = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_wrb,
  input  logic [7:0]  cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic [1:0]  rsp_status,
  output logic [17:0] tx_data,
  output logic        ld_tx_data,
  input  logic        tx_busy,
  input  logic [17:0] rx_data,
  input  logic        rx_empty,
  output logic        uld_rx_data,
  output logic [7:0]  drop_count
);
  typedef enum logic [2:0] {IDLE, DRAIN, LOAD, TX_WAIT, WAIT_RX, UNLOAD, CAPTURE, RESPOND} state_t;
  state_t state, state_n;
  logic [2:0] busy_sync;
  logic busy_s, busy_rise, timeout, accept;
  logic [TO_W-1:0] cnt;
  logic [16:0] pkt;
  assign busy_s = busy_sync[1];
  assign busy_rise = busy_sync[1] & ~busy_sync[2];
  assign timeout = cnt == TO_W'(TIMEOUT_CYCLES - 1);
  assign accept = cmd_valid & cmd_ready;
  assign pkt = {cmd_addr, cmd_wrb ? 8'h00 : cmd_data, cmd_wrb};
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    cmd_ready = 1'b0;
    ld_tx_data = 1'b0;
    uld_rx_data = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = rx_empty & ~busy_s;
        state_n = !rx_empty ? DRAIN : (cmd_valid & ~busy_s) ? LOAD : IDLE;
      end
      DRAIN: begin
        uld_rx_data = 1'b1;
        state_n = IDLE;
      end
      LOAD: begin
        ld_tx_data = 1'b1;
        state_n = busy_rise ? TX_WAIT : timeout ? RESPOND : LOAD;
      end
      TX_WAIT: state_n = busy_s ? TX_WAIT : tx_data[0] ? WAIT_RX : RESPOND;
      WAIT_RX: state_n = !rx_empty ? UNLOAD : timeout ? RESPOND : WAIT_RX;
      UNLOAD: begin
        uld_rx_data = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: state_n = RESPOND;
      RESPOND: begin
        rsp_valid = 1'b1;
        state_n = rsp_ready ? IDLE : RESPOND;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      busy_sync <= '0;
      cnt <= '0;
      tx_data <= '0;
      rsp_data <= '0;
      rsp_status <= '0;
      drop_count <= '0;
    end else begin
      busy_sync <= {busy_sync[1:0], tx_busy};
      cnt <= state_n != state ? '0 : cnt + 1'b1;
      if (accept) tx_data <= {~^pkt, pkt};
      if (state == DRAIN && drop_count != 8'hff) drop_count <= drop_count + 1'b1;
      if (state != RESPOND && state_n == RESPOND) begin
        rsp_data <= state == CAPTURE ? rx_data[8:1] : state == TX_WAIT ? tx_data[8:1] : 8'h00;
        rsp_status <= state == CAPTURE ? (~^rx_data ? 2'b01 : rx_data[16:9] != tx_data[16:9] ? 2'b10 : 2'b00)
                    : state == TX_WAIT ? 2'b00 : 2'b11;
      end
    end
endmodule

// File: tb/tb_uart_regfile_master.sv
// tb_uart_regfile_master: directed self-checking bench for uart_regfile_master
module tb_uart_regfile_master;
  logic clk = 1'b0, reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wrb = 1'b0;
  logic [7:0] cmd_addr = 8'h00, cmd_data = 8'h00;
  logic rsp_valid, rsp_ready = 1'b0;
  logic [7:0] rsp_data;
  logic [1:0] rsp_status;
  logic [17:0] tx_data;
  logic ld_tx_data, tx_busy = 1'b0;
  logic [17:0] rx_data = 18'h0;
  logic rx_empty = 1'b1, uld_rx_data;
  logic [7:0] drop_count;
  int checks = 0, passed = 0, uld_seen = 0;
  uart_regfile_master #(.TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wrb(cmd_wrb),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .tx_data(tx_data), .ld_tx_data(ld_tx_data),
    .tx_busy(tx_busy), .rx_data(rx_data), .rx_empty(rx_empty), .uld_rx_data(uld_rx_data),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (uld_rx_data) uld_seen <= uld_seen + 1;
  task automatic send_cmd(input logic wrb, input logic [7:0] addr, input logic [7:0] data, output bit ok);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wrb = wrb; cmd_addr = addr; cmd_data = data;
    #1;
    while (!cmd_ready && n < 20) begin @(negedge clk); #1; n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = n < 20;
  endtask
  task automatic wait_rsp(input int max, output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < max);
    if (!rsp_valid) n = -1;
  endtask
  task automatic ack_rsp;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if ({rsp_valid, ld_tx_data, uld_rx_data, cmd_ready} !== 4'b0001) $display("FAIL reset_ctrl: got %b expected 0001", {rsp_valid, ld_tx_data, uld_rx_data, cmd_ready}); else passed++;
    checks++; if ({rsp_data, rsp_status, tx_data, drop_count} !== 36'h0) $display("FAIL reset_data: got %h expected 0", {rsp_data, rsp_status, tx_data, drop_count}); else passed++;
  endtask
  task automatic test_write;
    bit ok;
    int n, u, hi;
    u = uld_seen;
    send_cmd(1'b0, 8'h01, 8'hab, ok);
    checks++; if (!ok) $display("FAIL write_accept: got no accept expected accept"); else passed++;
    checks++; if (tx_data !== 18'h20356) $display("FAIL write_tx_data: got %h expected 20356", tx_data); else passed++;
    hi = 0;
    repeat (6) begin if (ld_tx_data) hi++; @(negedge clk); end
    checks++; if (hi !== 6) $display("FAIL write_ld_hold: got %0d expected 6", hi); else passed++;
    tx_busy = 1'b1;
    hi = 0;
    repeat (2) begin @(negedge clk); if (ld_tx_data) hi++; end
    @(negedge clk);
    checks++; if (hi !== 2) $display("FAIL write_ld_until_busy_s: got %0d expected 2", hi); else passed++;
    checks++; if (ld_tx_data !== 1'b0) $display("FAIL write_ld_drop: got %b expected 0", ld_tx_data); else passed++;
    repeat (69) @(negedge clk);
    tx_busy = 1'b0;
    wait_rsp(10, n);
    checks++; if (n !== 3) $display("FAIL write_rsp_latency: got %0d expected 3", n); else passed++;
    checks++; if ({rsp_status, rsp_data} !== {2'b00, 8'hab}) $display("FAIL write_rsp: got %b/%h expected 00/ab", rsp_status, rsp_data); else passed++;
    checks++; if (uld_seen - u !== 0) $display("FAIL write_no_uld: got %0d expected 0", uld_seen - u); else passed++;
    ack_rsp;
    checks++; if ({rsp_valid, cmd_ready} !== 2'b01) $display("FAIL write_ack: got %b expected 01", {rsp_valid, cmd_ready}); else passed++;
  endtask
  task automatic test_read(input string name, input logic [17:0] reply, input logic [1:0] st, input logic [7:0] dat);
    bit ok;
    int n, u;
    u = uld_seen;
    send_cmd(1'b1, 8'h05, 8'h00, ok);
    checks++; if (tx_data !== 18'h00a01) $display("FAIL %s_tx_data: got %h expected 00a01", name, tx_data); else passed++;
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    repeat (4) @(negedge clk);
    rx_data = reply; rx_empty = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!uld_rx_data && n < 10);
    rx_empty = 1'b1;
    checks++; if (n !== 1) $display("FAIL %s_uld_latency: got %0d expected 1", name, n); else passed++;
    wait_rsp(10, n);
    checks++; if (n !== 2) $display("FAIL %s_rsp_latency: got %0d expected 2", name, n); else passed++;
    checks++; if ({rsp_status, rsp_data} !== {st, dat}) $display("FAIL %s_rsp: got %b/%h expected %b/%h", name, rsp_status, rsp_data, st, dat); else passed++;
    ack_rsp;
    checks++; if (uld_seen - u !== 1) $display("FAIL %s_uld_count: got %0d expected 1", name, uld_seen - u); else passed++;
  endtask
  task automatic test_read_timeout;
    bit ok;
    int n;
    send_cmd(1'b1, 8'h05, 8'h00, ok);
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    wait_rsp(100, n);
    checks++; if (n !== 67) $display("FAIL rx_timeout_latency: got %0d expected 67", n); else passed++;
    checks++; if ({rsp_status, rsp_data} !== {2'b11, 8'h00}) $display("FAIL rx_timeout_rsp: got %b/%h expected 11/00", rsp_status, rsp_data); else passed++;
    ack_rsp;
  endtask
  task automatic test_load_timeout;
    bit ok;
    int n;
    send_cmd(1'b0, 8'h01, 8'hab, ok);
    checks++; if (ld_tx_data !== 1'b1) $display("FAIL load_timeout_ld: got %b expected 1", ld_tx_data); else passed++;
    wait_rsp(100, n);
    checks++; if (n !== 64) $display("FAIL load_timeout_latency: got %0d expected 64", n); else passed++;
    checks++; if ({ld_tx_data, rsp_status, rsp_data} !== {1'b0, 2'b11, 8'h00}) $display("FAIL load_timeout_rsp: got %b/%b/%h expected 0/11/00", ld_tx_data, rsp_status, rsp_data); else passed++;
    ack_rsp;
  endtask
  task automatic test_drain;
    int n, u;
    u = uld_seen;
    @(negedge clk);
    rx_empty = 1'b0; cmd_valid = 1'b1; cmd_wrb = 1'b0; cmd_addr = 8'h01; cmd_data = 8'hab;
    #1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL drain_priority: got %b expected 0", cmd_ready); else passed++;
    @(negedge clk);
    checks++; if (uld_rx_data !== 1'b1) $display("FAIL drain_uld: got %b expected 1", uld_rx_data); else passed++;
    rx_empty = 1'b1;
    @(negedge clk);
    #1;
    checks++; if ({drop_count, cmd_ready} !== {8'd1, 1'b1}) $display("FAIL drain_count: got %0d/%b expected 1/1", drop_count, cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++; if (ld_tx_data !== 1'b1) $display("FAIL drain_then_accept: got %b expected 1", ld_tx_data); else passed++;
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    wait_rsp(10, n);
    checks++; if ({rsp_status, rsp_data} !== {2'b00, 8'hab}) $display("FAIL drain_write_rsp: got %b/%h expected 00/ab", rsp_status, rsp_data); else passed++;
    ack_rsp;
    checks++; if (uld_seen - u !== 1) $display("FAIL drain_uld_count: got %0d expected 1", uld_seen - u); else passed++;
  endtask
  task automatic test_drop_saturate;
    repeat (100) begin @(negedge clk); rx_empty = 1'b0; @(negedge clk); rx_empty = 1'b1; end
    @(negedge clk);
    checks++; if (drop_count !== 8'd101) $display("FAIL drop_count_101: got %0d expected 101", drop_count); else passed++;
    repeat (200) begin @(negedge clk); rx_empty = 1'b0; @(negedge clk); rx_empty = 1'b1; end
    @(negedge clk);
    checks++; if (drop_count !== 8'd255) $display("FAIL drop_count_sat: got %0d expected 255", drop_count); else passed++;
  endtask
  task automatic test_reset_mid;
    bit ok, stable;
    int n;
    send_cmd(1'b1, 8'h05, 8'h00, ok);
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, ld_tx_data, uld_rx_data, cmd_ready, rsp_data, rsp_status, tx_data, drop_count} !== {4'b0001, 36'h0}) $display("FAIL reset_wait_rx: got %h expected %h", {rsp_valid, ld_tx_data, uld_rx_data, cmd_ready, rsp_data, rsp_status, tx_data, drop_count}, {4'b0001, 36'h0}); else passed++;
    reset = 1'b0;
    test_write;
    send_cmd(1'b0, 8'h01, 8'hab, ok);
    tx_busy = 1'b1;
    repeat (20) @(negedge clk);
    tx_busy = 1'b0;
    wait_rsp(10, n);
    stable = 1'b1;
    repeat (20) begin @(negedge clk); if (rsp_valid !== 1'b1 || rsp_data !== 8'hab || rsp_status !== 2'b00) stable = 1'b0; end
    checks++; if (stable !== 1'b1) $display("FAIL rsp_hold: got unstable expected stable valid/ab/00"); else passed++;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, ld_tx_data, uld_rx_data, cmd_ready, rsp_data, rsp_status, tx_data, drop_count} !== {4'b0001, 36'h0}) $display("FAIL reset_respond: got %h expected %h", {rsp_valid, ld_tx_data, uld_rx_data, cmd_ready, rsp_data, rsp_status, tx_data, drop_count}, {4'b0001, 36'h0}); else passed++;
    reset = 1'b0;
    test_write;
  endtask
  initial begin
    test_reset;
    test_write;
    test_read("read_ok", 18'h00a79, 2'b00, 8'h3c);
    test_read("read_parity", 18'h20a79, 2'b01, 8'h3c);
    test_read("read_addr", 18'h00c79, 2'b10, 8'h3c);
    test_read_timeout;
    test_load_timeout;
    test_drain;
    test_drop_saturate;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_regfile_master.md
Name: uart_regfile_master

Overview:
- Host-side (FPGA) initiator for the PSD_CHIP regfile UART protocol. It is the counterpart of the chip's digital_core responder.
- Accepts read/write commands on a valid/ready port and builds 18-bit packets: bit 17 parity, 16:9 addr, 8:1 data, 0 wrb.
- Drives an external uart_tx load handshake and, for reads, retrieves the reply from an external uart_rx.
- Checks the reply and returns data plus a status code.

Parameters:
- TIMEOUT_CYCLES, 4096, clk cycles allowed in LOAD or WAIT_RX before abort.
- TO_W, $clog2(TIMEOUT_CYCLES)+1, timeout counter width.

Ports:
- clk  in  1  system clock; all logic is on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_wrb  in  1  0 = write, 1 = read.
- cmd_addr  in  8  regfile address.
- cmd_data  in  8  write data; ignored for reads.
- rsp_valid  out  1  response available; held until rsp_ready.
- rsp_ready  in  1  response accepted.
- rsp_data  out  8  read data, or echoed write data.
- rsp_status  out  2  00 ok, 01 parity error, 10 address mismatch, 11 timeout.
- tx_data  out  18  packet to uart_tx.
- ld_tx_data  out  1  load request to uart_tx.
- tx_busy  in  1  from uart_tx; txclk domain, asynchronous to clk.
- rx_data  in  18  reply word from uart_rx; clk domain.
- rx_empty  in  1  low = reply waiting; clk domain.
- uld_rx_data  out  1  unload pulse to uart_rx.
- drop_count  out  8  saturating count of unsolicited replies discarded.

Behaviour:
- Reset (synchronous, active-high) drives these outputs to 0: rsp_valid, rsp_data, rsp_status, tx_data, ld_tx_data, uld_rx_data, drop_count. It also clears the timeout counter and the tx_busy synchronizer, and puts the FSM in IDLE (so cmd_ready = 1 in the first cycle after reset). Reset mid-operation aborts with no response.
- tx_busy passes through a 2-flop synchronizer, giving busy_s. Every busy_s reference below means the synchronized value.
- Parity is odd: tx_data[17] = ~^tx_data[16:0]. The total number of 1s in the 18-bit word is odd.
- Accept happens on cmd_valid & cmd_ready in cycle N. tx_data and the command fields are registered at N. ld_tx_data = 1 from N+1. A write must also wait for busy_s low at accept time: cmd_ready = IDLE & ~busy_s.
- FSM states and transitions:
  - IDLE: if rx_empty = 0, go to DRAIN. Otherwise, on accept, go to LOAD.
  - DRAIN: uld_rx_data = 1 for exactly one cycle; drop_count increments, saturating at 255; return to IDLE. DRAIN takes priority over accept in the same cycle.
  - LOAD: ld_tx_data = 1 and the timeout counter runs. On the first rising edge of busy_s, drop ld_tx_data and go to TX_WAIT. On timeout, set status 11, data = 0, and go to RESPOND.
  - TX_WAIT: wait for busy_s = 0. For a write, go to RESPOND with status 00 and rsp_data = cmd_data. For a read, clear the timeout counter and go to WAIT_RX.
  - WAIT_RX: the timeout counter runs. When rx_empty = 0, go to UNLOAD. On timeout, go to RESPOND with status 11 and data = 0. If both happen in the same cycle, rx_empty wins.
  - UNLOAD: uld_rx_data = 1 for one cycle, then go to CAPTURE.
  - CAPTURE: sample rx_data, then classify:
    - parity: if ^rx_data != 1, status 01.
    - else address: if rx_data[16:9] != cmd_addr, status 10.
    - else status 00.
    - rsp_data = rx_data[8:1] in all cases.
    - The reply wrb bit is ignored.
    - Go to RESPOND.
  - RESPOND: rsp_valid = 1, with rsp_data and rsp_status stable. On rsp_ready, clear rsp_valid and go to IDLE. rsp_valid may be high only in RESPOND.
- Timeout: the counter clears on entry to LOAD and to WAIT_RX. Timeout fires when the counter reaches TIMEOUT_CYCLES-1, i.e. on the TIMEOUT_CYCLES-th cycle in that state.
- Only one command is outstanding at a time. No command is accepted while busy.

Test Plan:
- Write addr 0x01, data 0xab, with uart_tx busy for 18 txclk bits → tx_data = 0x20356 and ld_tx_data held until busy_s rises. After busy falls, rsp_valid with rsp_status = 00 and rsp_data = 0xab. No uld_rx_data pulse occurs.
- Read addr 0x05; bench returns rx_data = 0xA79 → tx_data = 0x00A01, a single uld_rx_data pulse, then rsp_data = 0x3c, rsp_status = 00.
- Read addr 0x05; reply 0x20A79 (bad parity) → status 01, rsp_data = 0x3c. Reply 0xC79 (addr 0x06) → status 10.
- TIMEOUT_CYCLES = 64: read with rx_empty held at 1 → rsp_status = 11 after 64 cycles in WAIT_RX. Separately, tx_busy stuck at 0 → status 11 after 64 LOAD cycles with ld_tx_data dropped.
- rx_empty goes low in IDLE with no command; bench also asserts cmd_valid in the same cycle → one uld_rx_data pulse, drop_count = 1, and the command is accepted next cycle. After 300 unsolicited replies, drop_count stays at 255.
- Assert reset in WAIT_RX and in RESPOND → in the next cycle all outputs = 0 and cmd_ready = 1. A subsequent write at 0x01/0xab completes normally. Hold rsp_ready low for 20 cycles → rsp_valid and rsp_data stay stable.
